// File: rtl/tx_am_scheduler.sv
// TX PCS sequencing controller: startup flush, per-stage enables and periodic AM gaps.
// Optional build macro TX_AM_PERIOD_PROG_EN adds the i_am_period port (runtime AM period).
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | stopped, all stage enables low
// S_STARTUP | flushing the chain for STARTUP_CYCLES cycles
// S_RUN     | one data block per cycle, block counter advancing
// S_AM_GAP  | NLANES-cycle hole for alignment markers, never truncated
module tx_am_scheduler #(
    parameter int NMODULES       = 2,
    parameter int NLANES         = 20,
    parameter int LEN_LANE       = 5,
    parameter int AM_PERIOD      = 16383,
    parameter int LEN_PERIOD     = 14,
    parameter int STARTUP_CYCLES = 4,
    parameter int STAGE_LATENCY  = 2
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_run,
`ifdef TX_AM_PERIOD_PROG_EN
    input  logic [LEN_PERIOD-1:0] i_am_period,
`endif
    output logic                  o_tx_ready,
    output logic [NMODULES-1:0]   o_enable,
    output logic                  o_am_gap,
    output logic                  o_am_insert,
    output logic [LEN_LANE-1:0]   o_am_lane,
    output logic [LEN_PERIOD-1:0] o_block_count
);

    localparam int SU_W   = (STARTUP_CYCLES > 1) ? $clog2(STARTUP_CYCLES) : 1;
    localparam int AM_DLY = NMODULES * STAGE_LATENCY;

    typedef enum logic [1:0] {
        S_IDLE,
        S_STARTUP,
        S_RUN,
        S_AM_GAP
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [SU_W-1:0]       su_cnt;
    logic [LEN_PERIOD-1:0] blk_cnt;
    logic [LEN_LANE-1:0]   lane_cnt;
    logic [LEN_PERIOD-1:0] period_w;
    logic                  su_last;
    logic                  blk_last;
    logic                  lane_last;

    logic                  en0_q;
    logic [LEN_LANE-1:0]   gap_lane_q;
    logic                  ins_sr  [AM_DLY];
    logic [LEN_LANE-1:0]   lane_sr [AM_DLY];
    wire  [NMODULES-1:0]   en_w;

`ifdef TX_AM_PERIOD_PROG_EN
    logic [LEN_PERIOD-1:0] period_q;
    logic [LEN_PERIOD-1:0] period_sel;

    // 0 and 1 are not meaningful periods; fall back to the default
    assign period_sel = (i_am_period < LEN_PERIOD'(2)) ? LEN_PERIOD'(AM_PERIOD) : i_am_period;
    assign period_w   = period_q;

    always_ff @(posedge i_clock) begin
        if (!i_reset)
            period_q <= LEN_PERIOD'(AM_PERIOD);
        else if (state_q == S_IDLE && i_run)
            period_q <= period_sel;
    end
`else
    assign period_w = LEN_PERIOD'(AM_PERIOD);
`endif

    assign su_last   = (su_cnt == SU_W'(STARTUP_CYCLES - 1));
    assign blk_last  = (blk_cnt == period_w - 1'b1);
    assign lane_last = (lane_cnt == LEN_LANE'(NLANES - 1));

    always_ff @(posedge i_clock) begin
        if (!i_reset)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (i_run) state_d = S_STARTUP;
            S_STARTUP: begin
                if (!i_run)       state_d = S_IDLE;
                else if (su_last) state_d = S_RUN;
            end
            S_RUN: begin
                if (!i_run)        state_d = S_IDLE;
                else if (blk_last) state_d = S_AM_GAP;
            end
            S_AM_GAP:  if (lane_last) state_d = i_run ? S_RUN : S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            su_cnt   <= '0;
            blk_cnt  <= '0;
            lane_cnt <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    su_cnt <= '0;
                    if (i_run) blk_cnt <= '0;
                end
                S_STARTUP: begin
                    su_cnt <= su_cnt + 1'b1;
                    if (su_last) blk_cnt <= '0;
                end
                S_RUN: begin
                    blk_cnt <= blk_last ? '0 : blk_cnt + 1'b1;
                    if (blk_last) lane_cnt <= '0;
                end
                S_AM_GAP: lane_cnt <= lane_last ? '0 : lane_cnt + 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            o_tx_ready    <= 1'b0;
            en0_q         <= 1'b0;
            o_am_gap      <= 1'b0;
            gap_lane_q    <= '0;
            o_block_count <= '0;
        end else begin
            o_tx_ready    <= (state_q == S_RUN);
            en0_q         <= (state_q == S_RUN);
            o_am_gap      <= (state_q == S_AM_GAP);
            gap_lane_q    <= (state_q == S_AM_GAP) ? lane_cnt : '0;
            o_block_count <= blk_cnt;
        end
    end

    // Marker flag and lane ride along the whole chain so they line up with its output
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            for (int i = 0; i < AM_DLY; i++) begin
                ins_sr[i]  <= 1'b0;
                lane_sr[i] <= '0;
            end
        end else begin
            ins_sr[0]  <= o_am_gap;
            lane_sr[0] <= gap_lane_q;
            for (int i = 1; i < AM_DLY; i++) begin
                ins_sr[i]  <= ins_sr[i-1];
                lane_sr[i] <= lane_sr[i-1];
            end
        end
    end

    assign o_am_insert = ins_sr[AM_DLY-1];
    assign o_am_lane   = lane_sr[AM_DLY-1];

    assign en_w[0] = en0_q;

    // Each stage's enable trails the previous stage's by STAGE_LATENCY cycles
    for (genvar k = 1; k < NMODULES; k++) begin : g_stage
        logic st_sr [STAGE_LATENCY];

        always_ff @(posedge i_clock) begin
            if (!i_reset) begin
                for (int i = 0; i < STAGE_LATENCY; i++) st_sr[i] <= 1'b0;
            end else begin
                st_sr[0] <= en_w[k-1];
                for (int i = 1; i < STAGE_LATENCY; i++) st_sr[i] <= st_sr[i-1];
            end
        end

        assign en_w[k] = st_sr[STAGE_LATENCY-1];
    end

    assign o_enable = en_w;

endmodule

// File: tb/tb_tx_am_scheduler.sv
// Scoreboard bench for tx_am_scheduler (AM_PERIOD=8, NLANES=4, STARTUP_CYCLES=4, 2 stages x 2).
module tb_tx_am_scheduler;

    localparam int NMODULES       = 2;
    localparam int NLANES         = 4;
    localparam int LEN_LANE       = 2;
    localparam int AM_PERIOD      = 8;
    localparam int LEN_PERIOD     = 14;
    localparam int STARTUP_CYCLES = 4;
    localparam int STAGE_LATENCY  = 2;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  run;
    logic                  o_tx_ready;
    logic [NMODULES-1:0]   o_enable;
    logic                  o_am_gap;
    logic                  o_am_insert;
    logic [LEN_LANE-1:0]   o_am_lane;
    logic [LEN_PERIOD-1:0] o_block_count;
`ifdef TX_AM_PERIOD_PROG_EN
    logic [LEN_PERIOD-1:0] am_period;
`endif

    int checks = 0;
    int errors = 0;
    int exp_bc_q[$];
    int exp_lane_q[$];

    always #5 clk = ~clk;

    tx_am_scheduler #(
        .NMODULES(NMODULES), .NLANES(NLANES), .LEN_LANE(LEN_LANE), .AM_PERIOD(AM_PERIOD),
        .LEN_PERIOD(LEN_PERIOD), .STARTUP_CYCLES(STARTUP_CYCLES), .STAGE_LATENCY(STAGE_LATENCY)
    ) dut (
        .i_clock      (clk),
        .i_reset      (rst_n),
        .i_run        (run),
`ifdef TX_AM_PERIOD_PROG_EN
        .i_am_period  (am_period),
`endif
        .o_tx_ready   (o_tx_ready),
        .o_enable     (o_enable),
        .o_am_gap     (o_am_gap),
        .o_am_insert  (o_am_insert),
        .o_am_lane    (o_am_lane),
        .o_block_count(o_block_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_zero(input string name);
        chk(name, {o_tx_ready, o_enable, o_am_gap, o_am_insert, o_am_lane, o_block_count}, 0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_period(input int nblk);
        for (int i = 0; i < nblk; i++) exp_bc_q.push_back(i);
        for (int i = 0; i < NLANES; i++) exp_lane_q.push_back(i);
    endtask

    // Monitor: every presented block / inserted marker consumes one expected entry
    always @(negedge clk) begin
        if (o_tx_ready === 1'b1) begin
            if (exp_bc_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL bc_unexpected: got block %0d expected none at %0t", o_block_count, $time);
            end else begin
                chk("block_count", o_block_count, exp_bc_q.pop_front());
            end
        end
        if (o_am_insert === 1'b1) begin
            if (exp_lane_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL lane_unexpected: got lane %0d expected none at %0t", o_am_lane, $time);
            end else begin
                chk("am_lane", o_am_lane, exp_lane_q.pop_front());
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        run   = 1'b1;
`ifdef TX_AM_PERIOD_PROG_EN
        am_period = '0;
`endif
        repeat (3) begin
            step();
            chk_zero("reset_hold");
        end
        rst_n = 1'b1;
        step();
        chk_zero("post_release");

        // startup, two full periods, stop requested inside the second gap
        push_period(AM_PERIOD);
        push_period(AM_PERIOD);
        for (int off = 1; off <= 33; off++) begin
            step();
            case (off)
                4:  chk("startup_ready", o_tx_ready, 0);
                5:  begin chk("run_ready", o_tx_ready, 1); chk("en_rise0", o_enable, 2'b01); end
                6:  chk("en_stage1_wait", o_enable, 2'b01);
                7:  chk("en_rise1", o_enable, 2'b11);
                12: chk("last_ready", o_tx_ready, 1);
                13: begin
                    chk("gap_ready", o_tx_ready, 0);
                    chk("gap_open", o_am_gap, 1);
                    chk("gap_enable", o_enable, 2'b10);
                end
                16: chk("gap_last", o_am_gap, 1);
                17: begin
                    chk("gap_close", o_am_gap, 0);
                    chk("insert_open", o_am_insert, 1);
                    chk("resume_ready", o_tx_ready, 1);
                end
                21: chk("insert_close", o_am_insert, 0);
                24: chk("period_ready", o_tx_ready, 1);
                25: begin chk("period_gap", o_am_gap, 1); run = 1'b0; end
                26: chk("stop_en1_hold", o_enable, 2'b10);
                27: chk("stop_en1_fall", o_enable, 2'b00);
                28: chk("gap_not_truncated", o_am_gap, 1);
                29: begin chk("idle_gap", o_am_gap, 0); chk("idle_ready", o_tx_ready, 0); end
                33: chk("insert_drained", o_am_insert, 0);
                default: ;
            endcase
        end

        // restart, reset mid-RUN at block 5
        for (int i = 0; i <= 5; i++) exp_bc_q.push_back(i);
        run = 1'b1;
        step();
        for (int off = 1; off <= 10; off++) begin
            step();
            if (off == 5)  chk("rerun_ready", o_tx_ready, 1);
            if (off == 10) chk("rerun_block5", o_block_count, 5);
        end
        rst_n = 1'b0;
        step();
        chk_zero("mid_reset");
        step();
        chk_zero("mid_reset_hold");
        step();
        chk("mid_reset_en1", o_enable, 0);

        // full startup again, stop after two blocks
        exp_bc_q.push_back(0);
        exp_bc_q.push_back(1);
        rst_n = 1'b1;
        step();
        for (int off = 1; off <= 9; off++) begin
            step();
            case (off)
                4: chk("restart_startup", o_tx_ready, 0);
                5: begin chk("restart_block0", o_block_count, 0); run = 1'b0; end
                7: chk("stop_ready", o_tx_ready, 0);
                9: chk("stop_drained", o_enable, 0);
                default: ;
            endcase
        end

`ifdef TX_AM_PERIOD_PROG_EN
        push_period(5);
        am_period = LEN_PERIOD'(5);
        run = 1'b1;
        step();
        for (int off = 1; off <= 18; off++) begin
            step();
            case (off)
                9:  chk("prog_last_ready", o_tx_ready, 1);
                10: chk("prog_gap", o_am_gap, 1);
                11: run = 1'b0;
                default: ;
            endcase
        end
`endif

        repeat (3) step();
        chk("bc_queue_left", exp_bc_q.size(), 0);
        chk("lane_queue_left", exp_lane_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
